// File: rtl/mips_hazard_ctrl.sv
// Hazard and run controller for the 5-stage MIPS pipeline: load-use stalls,
// branch squashes, EX forwarding selects, run/drain/halt sequencing and counters.
module mips_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic                  uses_rs_d,
    input  logic                  uses_rt_d,
    input  logic                  halt_d,
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rt_e,
    input  logic                  mem_read_e,
    input  logic                  reg_write_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] write_reg_w,
    input  logic                  pc_src_e,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] cycle_q, stall_q, flush_q;
    logic             load_use;
    logic             stall_inc, flush_inc, cycle_inc;

    // MEM result is younger than WB data, so it wins when both match.
    always_comb begin
        fwd_a = 2'b00;
        if (reg_write_m && write_reg_m != '0 && write_reg_m == rs_e)
            fwd_a = 2'b01;
        else if (reg_write_w && write_reg_w != '0 && write_reg_w == rs_e)
            fwd_a = 2'b10;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (reg_write_m && write_reg_m != '0 && write_reg_m == rt_e)
            fwd_b = 2'b01;
        else if (reg_write_w && write_reg_w != '0 && write_reg_w == rt_e)
            fwd_b = 2'b10;
    end

    assign load_use = mem_read_e && reg_write_e && (write_reg_e != '0) &&
                      ((uses_rs_d && rs_d == write_reg_e) ||
                       (uses_rt_d && rt_d == write_reg_e));

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        drain_d     = drain_q;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (pc_src_e) begin
                    pc_write  = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    if_id_flush = 1'b0;
                    stall_inc   = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b0;
                    id_ex_flush = 1'b0;
                    if (halt_d) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_HALTED;
                else               drain_d = drain_q - 1'b1;
            end
            default: ;
        endcase
    end

    assign cycle_inc = (state_q == S_RUN) || (state_q == S_DRAIN);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (cycle_inc && cycle_q != '1) cycle_q <= cycle_q + 1'b1;
            if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign running   = cycle_inc;
    assign halted    = (state_q == S_HALTED);
    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Randomized and directed bench for mips_hazard_ctrl, compared every cycle
// against a behavioural model of the run/hazard/forwarding rules.
module tb_mips_hazard_ctrl;

    localparam int RW   = 5;
    localparam int DRN  = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic          clk, reset_n, start;
    logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic          uses_rs_d, uses_rt_d, halt_d, mem_read_e, reg_write_e;
    logic          reg_write_m, reg_write_w, pc_src_e;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, running, halted;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_state = M_IDLE;
    int m_drain_left = 0;
    int m_cyc = 0, m_stl = 0, m_fls = 0;

    mips_hazard_ctrl #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DRN), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
        .halt_d(halt_d), .rs_e(rs_e), .rt_e(rt_e), .mem_read_e(mem_read_e),
        .reg_write_e(reg_write_e), .write_reg_e(write_reg_e),
        .reg_write_m(reg_write_m), .write_reg_m(write_reg_m),
        .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
        .pc_src_e(pc_src_e), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .running(running), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Which pipeline stage holds the newest value of register src.
    function automatic int fwd_ref(input int src);
        if (src == 0) return 0;
        if (reg_write_m && int'(write_reg_m) == src) return 1;
        if (reg_write_w && int'(write_reg_w) == src) return 2;
        return 0;
    endfunction

    task automatic clr_inputs();
        start = 0; rs_d = 0; rt_d = 0; uses_rs_d = 0; uses_rt_d = 0; halt_d = 0;
        rs_e = 0; rt_e = 0; mem_read_e = 0; reg_write_e = 0; write_reg_e = 0;
        reg_write_m = 0; write_reg_m = 0; reg_write_w = 0; write_reg_w = 0;
        pc_src_e = 0;
    endtask

    // Check all outputs for the inputs currently applied, then advance one clock.
    task automatic step();
        bit lu, loaded_rs, loaded_rt;
        int e_pc, e_ifw, e_iff, e_ief, n_state, n_left;
        int n_cyc, n_stl, n_fls;
        #3;
        loaded_rs = uses_rs_d && (rs_d == write_reg_e);
        loaded_rt = uses_rt_d && (rt_d == write_reg_e);
        lu = mem_read_e && reg_write_e && (write_reg_e != 0) && (loaded_rs || loaded_rt);
        e_pc = 0; e_ifw = 0; e_iff = 1; e_ief = 1;
        n_state = m_state; n_left = m_drain_left;
        n_cyc = m_cyc; n_stl = m_stl; n_fls = m_fls;
        if (m_state == M_RUN || m_state == M_DRAIN) n_cyc = sat_inc(m_cyc);
        if (m_state == M_IDLE && start) n_state = M_RUN;
        if (m_state == M_RUN) begin
            if (pc_src_e) begin
                e_pc = 1;
                n_fls = sat_inc(m_fls);
            end else if (lu) begin
                e_iff = 0;
                n_stl = sat_inc(m_stl);
            end else begin
                e_pc = 1; e_ifw = 1; e_iff = 0; e_ief = 0;
                if (halt_d) begin
                    n_state = M_DRAIN;
                    n_left  = DRN;
                end
            end
        end
        if (m_state == M_DRAIN) begin
            n_left = m_drain_left - 1;
            if (n_left == 0) n_state = M_HALTED;
        end
        check("pc_write", int'(pc_write), e_pc);
        check("if_id_write", int'(if_id_write), e_ifw);
        check("if_id_flush", int'(if_id_flush), e_iff);
        check("id_ex_flush", int'(id_ex_flush), e_ief);
        check("fwd_a", int'(fwd_a), fwd_ref(int'(rs_e)));
        check("fwd_b", int'(fwd_b), fwd_ref(int'(rt_e)));
        check("running", int'(running), int'(m_state == M_RUN || m_state == M_DRAIN));
        check("halted", int'(halted), int'(m_state == M_HALTED));
        check("cycle_cnt", int'(cycle_cnt), m_cyc);
        check("stall_cnt", int'(stall_cnt), m_stl);
        check("flush_cnt", int'(flush_cnt), m_fls);
        @(posedge clk);
        if (!reset_n) begin
            m_state = M_IDLE; m_drain_left = 0;
            m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            m_state = n_state; m_drain_left = n_left;
            m_cyc = n_cyc; m_stl = n_stl; m_fls = n_fls;
        end
        #1;
    endtask

    task automatic do_reset_and_start();
        clr_inputs();
        reset_n = 0;
        step();
        reset_n = 1;
        start = 1;
        step();
        start = 0;
    endtask

    initial begin
        clr_inputs();
        reset_n = 0;
        @(posedge clk);
        #1;
        step();
        step();
        reset_n = 1;

        // Reset in the middle of a run with nine counted cycles.
        start = 1;
        step();
        start = 0;
        repeat (9) step();
        check("cyc_before_rst", int'(cycle_cnt), 9);
        do_reset_and_start();
        check("run_after_start", int'(running), 1);

        // Load into $8 followed by a reader of $8, then WB forwarding.
        mem_read_e = 1; reg_write_e = 1; write_reg_e = 8;
        uses_rs_d = 1; rs_d = 8; rt_d = 1; uses_rt_d = 1;
        step();
        clr_inputs();
        reg_write_w = 1; write_reg_w = 8; rs_e = 8; rt_e = 1;
        step();

        // MEM beats WB; register 0 is never forwarded.
        clr_inputs();
        reg_write_m = 1; write_reg_m = 3; reg_write_w = 1; write_reg_w = 3;
        rs_e = 3; rt_e = 3;
        step();
        write_reg_m = 0; rs_e = 0;
        step();

        // Taken branch beats load-use and halt.
        clr_inputs();
        mem_read_e = 1; reg_write_e = 1; write_reg_e = 5; uses_rt_d = 1; rt_d = 5;
        halt_d = 1; pc_src_e = 1;
        step();

        // Clean halt: drain, halt, then ignore start.
        clr_inputs();
        halt_d = 1;
        step();
        halt_d = 0;
        repeat (DRN + 2) step();
        check("halted_after_drain", int'(halted), 1);
        start = 1;
        step();
        start = 0;
        step();

        // Twenty consecutive stalls saturate the counter.
        do_reset_and_start();
        mem_read_e = 1; reg_write_e = 1; write_reg_e = 7; uses_rs_d = 1; rs_d = 7;
        repeat (20) step();
        check("stall_sat", int'(stall_cnt), CMAX);
        clr_inputs();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset_n     = ($urandom_range(0, 99) != 0);
            start       = ($urandom_range(0, 7) == 0);
            rs_d        = RW'($urandom_range(0, 3));
            rt_d        = RW'($urandom_range(0, 3));
            uses_rs_d   = $urandom_range(0, 1);
            uses_rt_d   = $urandom_range(0, 1);
            halt_d      = ($urandom_range(0, 29) == 0);
            rs_e        = RW'($urandom_range(0, 3));
            rt_e        = RW'($urandom_range(0, 3));
            mem_read_e  = ($urandom_range(0, 2) == 0);
            reg_write_e = ($urandom_range(0, 3) != 0);
            write_reg_e = RW'($urandom_range(0, 3));
            reg_write_m = $urandom_range(0, 1);
            write_reg_m = RW'($urandom_range(0, 3));
            reg_write_w = $urandom_range(0, 1);
            write_reg_w = RW'($urandom_range(0, 3));
            pc_src_e    = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
